// File: rtl/stage3_mem_lsu_if.sv
// Execute->mem entry, data-bus and writeback signals of the memory-stage LSU.
// Handshake: the upstream entry is consumed at the end of any cycle with stall=0; a bus request stays asserted with stable address/data until dbus_busy=0 is seen.
interface stage3_mem_lsu_if;
    logic        req_valid;
    logic        req_ren;
    logic        req_wen;
    logic        req_reg_write;
    logic [31:0] req_result;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign_ext;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic        dbus_ren;
    logic        dbus_wen;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byte_en;
    logic        dbus_busy;
    logic [31:0] dbus_rdata;
    logic        reg_write;
    logic [4:0]  rd_m;
    logic [31:0] reg_wdata;
    logic        misaligned_load;
    logic        misaligned_store;

    modport slave (
        input  req_valid, req_ren, req_wen, req_reg_write, req_result, req_addr,
               req_wdata, req_size, req_sign_ext, req_rd, flush, dbus_busy, dbus_rdata,
        output stall, dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
               reg_write, rd_m, reg_wdata, misaligned_load, misaligned_store
    );

    modport master (
        output req_valid, req_ren, req_wen, req_reg_write, req_result, req_addr,
               req_wdata, req_size, req_sign_ext, req_rd, flush, dbus_busy, dbus_rdata,
        input  stall, dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
               reg_write, rd_m, reg_wdata, misaligned_load, misaligned_store
    );
endinterface

// File: rtl/stage3_mem_lsu.sv
// Memory-stage load/store unit: one data-bus transaction per aligned memory entry,
// byte-lane steering, load extension, misalignment pulses and non-memory pass-through.
module stage3_mem_lsu (
    input  logic             CLK,
    input  logic             RST,
    stage3_mem_lsu_if.slave  lsu,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_load_q, is_load_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        killed_q, killed_d;
    logic [31:0] ldata_q, ldata_d;
    logic        mis_load_q, mis_load_d;
    logic        mis_store_q, mis_store_d;

    logic        is_mem, half_sz, word_sz, misaligned, take;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Decode of the incoming entry and store lane steering
    always_comb begin
        is_mem     = lsu.req_ren | lsu.req_wen;
        half_sz    = (lsu.req_size == 2'b01);
        word_sz    = lsu.req_size[1];
        misaligned = (half_sz & lsu.req_addr[0]) |
                     (word_sz & (lsu.req_addr[1:0] != 2'b00));
        take       = (state_q == IDLE) & lsu.req_valid & ~lsu.flush & is_mem;
        if (word_sz) begin
            be_new    = 4'b1111;
            wdata_new = lsu.req_wdata;
        end else if (half_sz) begin
            be_new    = 4'b0011 << {lsu.req_addr[1], 1'b0};
            wdata_new = {2{lsu.req_wdata[15:0]}};
        end else begin
            be_new    = 4'b0001 << lsu.req_addr[1:0];
            wdata_new = {4{lsu.req_wdata[7:0]}};
        end
    end

    // Load extraction uses the latched address, since req_addr is only held, not owned
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = lsu.dbus_rdata[7:0];
            2'd1:    ld_byte = lsu.dbus_rdata[15:8];
            2'd2:    ld_byte = lsu.dbus_rdata[23:16];
            default: ld_byte = lsu.dbus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? lsu.dbus_rdata[31:16] : lsu.dbus_rdata[15:0];
        if (size_q[1]) begin
            ld_fmt = lsu.dbus_rdata;
        end else if (size_q == 2'b01) begin
            ld_fmt = {{16{sign_q & ld_half[15]}}, ld_half};
        end else begin
            ld_fmt = {{24{sign_q & ld_byte[7]}}, ld_byte};
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        sign_d      = sign_q;
        rd_d        = rd_q;
        is_load_d   = is_load_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        killed_d    = killed_q;
        ldata_d     = ldata_q;
        mis_load_d  = 1'b0;
        mis_store_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (misaligned) begin
                        mis_load_d  = lsu.req_ren;
                        mis_store_d = lsu.req_wen;
                    end else begin
                        addr_d    = lsu.req_addr;
                        size_d    = lsu.req_size;
                        sign_d    = lsu.req_sign_ext;
                        rd_d      = lsu.req_rd;
                        is_load_d = lsu.req_ren;
                        wdata_d   = wdata_new;
                        be_d      = be_new;
                        killed_d  = 1'b0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                // A flush never aborts the bus transaction; it only kills the writeback
                killed_d = killed_q | lsu.flush;
                if (!lsu.dbus_busy) begin
                    ldata_d = ld_fmt;
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            rd_q        <= '0;
            is_load_q   <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            killed_q    <= 1'b0;
            ldata_q     <= '0;
            mis_load_q  <= 1'b0;
            mis_store_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            rd_q        <= rd_d;
            is_load_q   <= is_load_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            killed_q    <= killed_d;
            ldata_q     <= ldata_d;
            mis_load_q  <= mis_load_d;
            mis_store_q <= mis_store_d;
        end
    end

    always_comb begin
        lsu.stall            = ~RST & ((state_q == REQ) | (take & ~misaligned));
        lsu.dbus_ren         = (state_q == REQ) & is_load_q;
        lsu.dbus_wen         = (state_q == REQ) & ~is_load_q;
        lsu.dbus_addr        = {addr_q[31:2], 2'b00};
        lsu.dbus_wdata       = wdata_q;
        lsu.dbus_byte_en     = be_q;
        lsu.misaligned_load  = mis_load_q;
        lsu.misaligned_store = mis_store_q;
        lsu.reg_write        = 1'b0;
        lsu.rd_m             = rd_q;
        lsu.reg_wdata        = ldata_q;
        if (state_q == IDLE) begin
            lsu.rd_m      = lsu.req_rd;
            lsu.reg_wdata = lsu.req_result;
            lsu.reg_write = ~RST & lsu.req_valid & ~lsu.flush & ~is_mem &
                            lsu.req_reg_write & (lsu.req_rd != 5'd0);
        end else if (state_q == WB) begin
            lsu.reg_write = ~RST & is_load_q & ~killed_q & ~lsu.flush & (rd_q != 5'd0);
        end
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_stage3_mem_lsu.sv
// Bench for stage3_mem_lsu: directed scenarios plus random entries against a
// cycle-level reference model of the LSU protocol and data formatting.
module tb_stage3_mem_lsu;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    stage3_mem_lsu_if bus();

    stage3_mem_lsu dut (
        .CLK       (clk),
        .RST       (rst),
        .lsu       (bus),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sx);
        int unsigned v, nb, off;
        if (sz[1]) return rdata;
        nb  = (sz == 2'b01) ? 16 : 8;
        off = (a % 4) - ((a % 4) % (nb / 8));
        v   = (rdata >> (8 * off)) % (32'd1 << nb);
        if (sx && v >= (32'd1 << (nb - 1))) v = v - (32'd1 << nb);
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 4'(1 << (a % 4));
        if (sz == 2'b01) return 4'(3 << ((a % 4) & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // Present one entry, play the memory for busy_n busy cycles, check every cycle,
    // then one idle cycle to observe the misalignment pulse. flush_at<0: no flush.
    task automatic run_entry(input bit ren, input bit wen, input bit rw,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] res, input logic [1:0] size,
                             input bit sx, input logic [4:0] rd, input int busy_n,
                             input logic [31:0] rdata, input int flush_at);
        bit mem, dead, mis, aligned, exp_wr;
        int k, last;
        logic [31:0] exp_data;
        logic [36:0] e;
        mem      = ren | wen;
        dead     = (flush_at == 0);
        mis      = mem && !dead && model_mis(addr, size);
        aligned  = mem && !dead && !mis;
        k        = busy_n + 1;
        last     = aligned ? k + 1 : 0;
        exp_wr   = 1'b0;
        exp_data = res;
        if (!mem) begin
            exp_wr = rw && (rd != 0) && !dead;
        end else if (aligned && ren) begin
            exp_wr   = (rd != 0) && (flush_at < 0 || flush_at > last);
            exp_data = model_load(rdata, addr, size, sx);
        end
        if (exp_wr) exp_q.push_back({rd, exp_data});
        bus.req_valid     = 1'b1;
        bus.req_ren       = ren;
        bus.req_wen       = wen;
        bus.req_reg_write = rw;
        bus.req_addr      = addr;
        bus.req_wdata     = wd;
        bus.req_result    = res;
        bus.req_size      = size;
        bus.req_sign_ext  = sx;
        bus.req_rd        = rd;
        for (int c = 0; c <= last; c++) begin
            bus.flush      = (c == flush_at);
            bus.dbus_busy  = (c >= 1 && c <= busy_n);
            bus.dbus_rdata = bus.dbus_busy ? $urandom : rdata;
            @(negedge clk);
            chk("stall", bus.stall, aligned && c <= k);
            chk("dbus_ren", bus.dbus_ren, aligned && ren && c >= 1 && c <= k);
            chk("dbus_wen", bus.dbus_wen, aligned && wen && c >= 1 && c <= k);
            chk("mis_ld_in", bus.misaligned_load, 0);
            chk("mis_st_in", bus.misaligned_store, 0);
            if (aligned && c >= 1 && c <= k) begin
                chk("dbus_addr", bus.dbus_addr, addr & 32'hFFFF_FFFC);
                if (wen) begin
                    chk("byte_en", bus.dbus_byte_en, model_be(addr, size));
                    chk("dbus_wdata", bus.dbus_wdata, model_wdata(wd, size));
                end
            end
            chk("reg_write", bus.reg_write, exp_wr && c == last);
            if (bus.reg_write) begin
                if (exp_q.size() == 0) begin
                    chk("wb_extra", bus.reg_write, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_m", bus.rd_m, e[36:32]);
                    chk("reg_wdata", bus.reg_wdata, e[31:0]);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.dbus_busy = 1'b0;
        @(negedge clk);
        chk("mis_ld", bus.misaligned_load, mis && ren);
        chk("mis_st", bus.misaligned_store, mis && wen);
        chk("idle_stall", bus.stall, 0);
        chk("idle_ren", bus.dbus_ren, 0);
        chk("idle_wen", bus.dbus_wen, 0);
        chk("idle_wr", bus.reg_write, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ren, wen;
        int fl;
        logic [1:0] sz;
        rst = 1'b1;
        bus.req_valid = 0; bus.req_ren = 0; bus.req_wen = 0; bus.req_reg_write = 0;
        bus.req_result = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_size = 0;
        bus.req_sign_ext = 0; bus.req_rd = 0; bus.flush = 0; bus.dbus_busy = 0;
        bus.dbus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", bus.stall, 0);
        chk("rst_wr", bus.reg_write, 0);
        chk("rst_ren", bus.dbus_ren, 0);
        chk("rst_wen", bus.dbus_wen, 0);
        chk("rst_misl", bus.misaligned_load, 0);
        chk("rst_miss", bus.misaligned_store, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;

        run_entry(1, 0, 0, 32'h103, 0, 0, 2'b00, 1, 5'd7, 0, 32'h80FF_0000, -1);
        run_entry(0, 1, 0, 32'h202, 32'h1234_ABCD, 0, 2'b01, 0, 5'd3, 3, 0, -1);
        run_entry(1, 0, 0, 32'h301, 0, 0, 2'b10, 0, 5'd4, 0, 0, -1);
        run_entry(0, 1, 0, 32'h402, 32'h5555_6666, 0, 2'b11, 0, 5'd4, 0, 0, -1);
        run_entry(1, 0, 0, 32'h502, 0, 0, 2'b01, 0, 5'd9, 2, 32'hC3A5_0F00, 1);
        run_entry(1, 0, 0, 32'h502, 0, 0, 2'b01, 0, 5'd9, 0, 32'hC3A5_0F00, 2);
        run_entry(1, 0, 0, 32'h600, 0, 0, 2'b10, 0, 5'd0, 1, 32'h1111_2222, -1);
        run_entry(0, 0, 1, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 5'd5, 0, 0, -1);
        run_entry(0, 0, 1, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 5'd0, 0, 0, -1);
        run_entry(1, 0, 0, 32'h706, 0, 0, 2'b01, 1, 5'd12, 1, 32'h8001_7FFF, -1);

        // Reset while a request is outstanding must drop it at the next edge
        bus.req_valid = 1; bus.req_ren = 1; bus.req_wen = 0; bus.req_addr = 32'h800;
        bus.req_size = 2'b10; bus.req_rd = 5'd2; bus.dbus_busy = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_ren", bus.dbus_ren, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 0;
        bus.dbus_busy = 0;
        @(negedge clk);
        chk("rst_mid_stall", bus.stall, 0);
        chk("rst_mid_ren", bus.dbus_ren, 0);
        chk("rst_mid_state", dbg_state, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0:       begin ren = 1; wen = 0; end
                1:       begin ren = 0; wen = 1; end
                default: begin ren = 0; wen = 0; end
            endcase
            sz = 2'($urandom_range(0, 3));
            fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_entry(ren, wen, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, sz,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      $urandom_range(0, 3), $urandom, fl);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stage3_mem_lsu.md
# stage3_mem_lsu

Load/store unit for the memory stage of the 3-stage pipeline. Consumes the execute→mem entry (address, store data, size, signedness, destination), runs one data-bus transaction per memory instruction, and produces the writeback triple (reg_write, rd_m, reg_wdata). Stalls the upstream stages until the access completes. Handles byte-lane steering, load sign/zero extension and misalignment detection.

## Interface
- No parameters; XLEN fixed at 32.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  execute→mem entry valid
- req_ren / req_wen  in  1 each  load / store (never both)
- req_reg_write  in  1  non-memory instruction writes rd
- req_result  in  32  ALU result for non-memory writeback
- req_addr  in  32  effective address
- req_wdata  in  32  store data (low bits significant)
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_sign_ext  in  1  1 = signed load
- req_rd  in  5  destination register
- flush  in  1  discard current entry's architectural effect
- stall  out  1  hold execute→mem entry and upstream stages
- dbus_ren / dbus_wen  out  1 each  data-bus request
- dbus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- dbus_wdata  out  32  lane-replicated store data
- dbus_byte_en  out  4  byte enables
- dbus_busy  in  1  1 = transaction not yet complete
- dbus_rdata  in  32  read data, valid when dbus_busy=0
- reg_write  out  1  writeback enable
- rd_m  out  5  writeback register
- reg_wdata  out  32  writeback data
- misaligned_load / misaligned_store  out  1 each  one-cycle exception pulse

## Operation
- FSM states: IDLE, REQ, WB. Reset → IDLE; all registered outputs 0.
- IDLE, req_valid=0 or flush=1: stall=0, reg_write=0, no bus activity.
- IDLE, non-memory entry (ren=wen=0): pass-through, combinational: reg_write=req_reg_write && rd≠0, rd_m=req_rd, reg_wdata=req_result; stall=0.
- IDLE, memory entry, misaligned (half with addr[0]=1; word with addr[1:0]≠0): no bus access, no writeback; registered misaligned_load/store pulse next cycle; stall=0; stay IDLE.
- IDLE, memory entry, aligned: latch addr, size, sign, rd, op, lane data; stall=1; → REQ.
- REQ: dbus_ren/dbus_wen asserted from registers, address/data/byte_en stable; stall=1. When dbus_busy=0: register formatted load data, drop bus request next edge, → WB.
- WB: stall=0; for loads reg_write=1 unless rd=0 or entry flushed; rd_m/reg_wdata from registers; stores: reg_write=0. → IDLE.
- Store byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. dbus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; extend with sign bit if req_sign_ext else zeros.
- flush while in REQ: bus transaction runs to completion (no abort); latched "killed" flag suppresses WB reg_write. flush in WB suppresses reg_write that cycle.
- RST in any state → IDLE next edge, bus request dropped, stall=0.

## Timing
- Aligned memory op: accepted cycle 0 (stall=1), bus request visible cycles 1..k, dbus_busy sampled low in cycle k, writeback cycle k+1 with stall=0. Minimum latency (busy low on first request cycle): 3 cycles, stall high 2 cycles.
- Non-memory entries: 0-cycle, no stall.
- Misaligned: pulse exactly one cycle, cycle after acceptance; no stall.
- Upstream must hold req_* stable while stall=1; entry advances at end of the stall=0 cycle.
- dbus_ren and dbus_wen never high simultaneously; never high outside REQ.

## Test plan
- Reset: RST high 2 cycles → stall=0, reg_write=0, dbus_ren=dbus_wen=0, misaligned_*=0.
- Signed byte load addr 0x103, dbus_rdata=0x80FF_0000, busy low on first cycle → reg_wdata=0xFFFF_FF80, rd_m=req_rd, reg_write in cycle 2, stall high cycles 0–1.
- Half store addr 0x202, wdata=0x1234_ABCD, busy high 3 cycles → dbus_byte_en=1100, dbus_wdata=0xABCD_ABCD, dbus_addr=0x200, stall high cycles 0–4, reg_write=0.
- Word load addr 0x301 → misaligned_load=1 for exactly one cycle, no dbus_ren, stall=0.
- Unsigned half load, flush asserted during REQ → bus completes, WB reg_write=0; rd=x0 load → reg_write=0.
- Non-memory entry req_reg_write=1, rd=5, result=0xDEAD_BEEF → same-cycle reg_write=1, reg_wdata=0xDEAD_BEEF, stall=0.
